nearest_sample_search: RTL and testbench

Sequential front-end for the less-distance comparator stage. It captures an 8-bit reference and accepts a frame of N 8-bit samples over a valid/ready stream. For each sample it feeds the comparator with (reference, current best, new sample) and registers the comparator's winner. At end of frame it presents the sample closest to the reference, its distance and its position, held until acknowledged.

---
 rtl/nearest_sample_search.sv | 137 +++++++++++++
 tb/tb_nearest_sample_search.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/nearest_sample_search.sv
// nearest_sample_search
//
// Sequential front-end for the less-distance comparator. A start pulse in
// IDLE captures an 8-bit reference. A frame of N unsigned 8-bit samples then
// arrives over a valid/ready stream. Each accepted sample is compared with the
// current best by absolute distance to the reference. After the N-th sample
// the closest sample, its distance and its 0-based position are presented.
// They are held until the consumer acknowledges them.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; clears state and all registers
//   start      begin a frame (honoured only in IDLE)
//   ref_in     reference value, captured on the edge that accepts start
//   in_valid   in_data is valid
//   in_data    sample value, unsigned
//   in_ready   block accepts a sample this cycle (COLLECT)
//   out_valid  result valid, held until out_ack (DONE)
//   out_data   closest sample of the frame
//   out_dist   |ref - out_data|
//   out_index  0-based position of out_data within the frame
//   out_ack    consumer has taken the result
//   busy       high in COLLECT and DONE
module nearest_sample_search #(
  parameter int N = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] ref_in,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic [7:0] out_dist,
  output logic [7:0] out_index,
  input  logic       out_ack,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Count value held while the last sample of the frame is being accepted.
  localparam logic [8:0] LAST_CNT = 9'(N - 1);

  state_t     state_q, state_d;
  logic [7:0] ref_q, ref_d;
  logic [7:0] best_q, best_d;
  logic [7:0] bdist_q, bdist_d;
  logic [7:0] bidx_q, bidx_d;
  logic [8:0] cnt_q, cnt_d;

  logic [7:0] dist_p0;
  logic       take_p0;

  // Unsigned absolute difference: larger minus smaller, so it never wraps.
  function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] d;
    if (a >= b) d = a - b;
    else        d = b - a;
    return d;
  endfunction

  // Comparator stage: the first sample always wins. After that the stored
  // best is replaced only on a strictly smaller distance, so ties keep the
  // earlier sample.
  always_comb begin
    dist_p0 = abs_diff(ref_q, in_data);
    take_p0 = (cnt_q == 9'd0) || (bdist_q > dist_p0);
  end

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    best_d  = best_q;
    bdist_d = bdist_q;
    bidx_d  = bidx_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          ref_d   = ref_in;
          cnt_d   = 9'd0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        // in_ready is high throughout COLLECT, so in_valid alone means accept.
        if (in_valid) begin
          if (take_p0) begin
            best_d  = in_data;
            bdist_d = dist_p0;
            bidx_d  = cnt_q[7:0];
          end
          cnt_d = cnt_q + 9'd1;
          if (cnt_q == LAST_CNT) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ref_q   <= 8'd0;
      best_q  <= 8'd0;
      bdist_q <= 8'd0;
      bidx_q  <= 8'd0;
      cnt_q   <= 9'd0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      best_q  <= best_d;
      bdist_q <= bdist_d;
      bidx_q  <= bidx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == COLLECT);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = best_q;
  assign out_dist  = bdist_q;
  assign out_index = bidx_q;

endmodule

// File: tb/tb_nearest_sample_search.sv
module tb_nearest_sample_search;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  // Index 0: N=4, index 1: N=2, index 2: N=256
  logic       start_s [3];
  logic [7:0] ref_s   [3];
  logic       inv_s   [3];
  logic [7:0] ind_s   [3];
  logic       ack_s   [3];
  logic       rdy_s   [3];
  logic       ov_s    [3];
  logic [7:0] od_s    [3];
  logic [7:0] odist_s [3];
  logic [7:0] oidx_s  [3];
  logic       busy_s  [3];

  nearest_sample_search #(.N(4)) u_n4 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .ref_in(ref_s[0]),
    .in_valid(inv_s[0]), .in_data(ind_s[0]), .in_ready(rdy_s[0]),
    .out_valid(ov_s[0]), .out_data(od_s[0]), .out_dist(odist_s[0]),
    .out_index(oidx_s[0]), .out_ack(ack_s[0]), .busy(busy_s[0])
  );

  nearest_sample_search #(.N(2)) u_n2 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .ref_in(ref_s[1]),
    .in_valid(inv_s[1]), .in_data(ind_s[1]), .in_ready(rdy_s[1]),
    .out_valid(ov_s[1]), .out_data(od_s[1]), .out_dist(odist_s[1]),
    .out_index(oidx_s[1]), .out_ack(ack_s[1]), .busy(busy_s[1])
  );

  nearest_sample_search #(.N(256)) u_n256 (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]), .ref_in(ref_s[2]),
    .in_valid(inv_s[2]), .in_data(ind_s[2]), .in_ready(rdy_s[2]),
    .out_valid(ov_s[2]), .out_data(od_s[2]), .out_dist(odist_s[2]),
    .out_index(oidx_s[2]), .out_ack(ack_s[2]), .busy(busy_s[2])
  );

  typedef struct {
    int         u;
    logic [7:0] r;
    int         n;
    logic [7:0] s [4];
    logic [7:0] ed;
    logic [7:0] edist;
    logic [7:0] eidx;
  } vec_t;

  vec_t       tbl [7];
  int         tests = 0;
  int         fails = 0;
  logic [7:0] q_s [$];
  bit         q_v [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_vec(input int k, input int u, input logic [7:0] r, input int n,
                         input logic [7:0] s0, input logic [7:0] s1,
                         input logic [7:0] s2, input logic [7:0] s3,
                         input logic [7:0] ed, input logic [7:0] edist,
                         input logic [7:0] eidx);
    tbl[k].u = u; tbl[k].r = r; tbl[k].n = n;
    tbl[k].s[0] = s0; tbl[k].s[1] = s1; tbl[k].s[2] = s2; tbl[k].s[3] = s3;
    tbl[k].ed = ed; tbl[k].edist = edist; tbl[k].eidx = eidx;
  endtask

  task automatic check_res(input int u, input logic [7:0] ed, input logic [7:0] edist,
                           input logic [7:0] eidx, input string tag);
    chk($sformatf("%s out_valid", tag), 32'(ov_s[u]), 32'd1);
    chk($sformatf("%s out_data", tag), 32'(od_s[u]), 32'(ed));
    chk($sformatf("%s out_dist", tag), 32'(odist_s[u]), 32'(edist));
    chk($sformatf("%s out_index", tag), 32'(oidx_s[u]), 32'(eidx));
    chk($sformatf("%s busy", tag), 32'(busy_s[u]), 32'd1);
    chk($sformatf("%s in_ready", tag), 32'(rdy_s[u]), 32'd0);
  endtask

  // Starts a frame on unit u with samples from q_s and in_valid pattern q_v
  // (all ones past its end). Called and returns at 1 time unit after an edge.
  // With junk set, start=1 / ref_in=200 is held throughout COLLECT.
  task automatic run_frame(input int u, input logic [7:0] r, input bit junk, input string tag);
    int i, cyc, edges, zeros;
    bit acc, ov_early;
    zeros = 0;
    foreach (q_v[k]) if (!q_v[k]) zeros++;
    start_s[u] = 1'b1;
    ref_s[u]   = r;
    @(posedge clk); #1;
    edges = 1;
    start_s[u] = junk;
    ref_s[u]   = junk ? 8'd200 : r;
    chk($sformatf("%s in_ready after start", tag), 32'(rdy_s[u]), 32'd1);
    i = 0; cyc = 0; ov_early = 1'b0;
    while (i < q_s.size() && cyc < 1000) begin
      inv_s[u] = (cyc < q_v.size()) ? q_v[cyc] : 1'b1;
      ind_s[u] = q_s[i];
      acc = inv_s[u] & rdy_s[u];
      if (ov_s[u]) ov_early = 1'b1;
      @(posedge clk); #1;
      edges++; cyc++;
      if (acc) i++;
    end
    inv_s[u]   = 1'b0;
    start_s[u] = 1'b0;
    chk($sformatf("%s out_valid low during frame", tag), 32'(ov_early), 32'd0);
    chk($sformatf("%s edges start to out_valid", tag), 32'(edges),
        32'(q_s.size() + 1 + zeros));
  endtask

  task automatic do_ack(input int u, input string tag);
    ack_s[u] = 1'b1;
    @(posedge clk); #1;
    ack_s[u] = 1'b0;
    chk($sformatf("%s out_valid after ack", tag), 32'(ov_s[u]), 32'd0);
    chk($sformatf("%s busy after ack", tag), 32'(busy_s[u]), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int u = 0; u < 3; u++) begin
      start_s[u] = 1'b0; ref_s[u] = 8'd0; inv_s[u] = 1'b0;
      ind_s[u] = 8'd0; ack_s[u] = 1'b0;
    end

    // Directed frames: {unit, ref, n, samples, expected data/dist/index}
    set_vec(0, 0, 8'd100, 4, 8'd90,  8'd120, 8'd105, 8'd95,  8'd105, 8'd5,   8'd2);
    set_vec(1, 1, 8'd0,   2, 8'd255, 8'd1,   8'd0,   8'd0,   8'd1,   8'd1,   8'd1);
    set_vec(2, 1, 8'd255, 2, 8'd0,   8'd254, 8'd0,   8'd0,   8'd254, 8'd1,   8'd1);
    set_vec(3, 0, 8'd10,  4, 8'd10,  8'd10,  8'd10,  8'd10,  8'd10,  8'd0,   8'd0);
    set_vec(4, 0, 8'd0,   4, 8'd200, 8'd150, 8'd100, 8'd255, 8'd100, 8'd100, 8'd2);
    set_vec(5, 1, 8'd128, 2, 8'd127, 8'd129, 8'd0,   8'd0,   8'd127, 8'd1,   8'd0);
    set_vec(6, 0, 8'd255, 4, 8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd255, 8'd0);

    #12;
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("reset u%0d in_ready", u), 32'(rdy_s[u]), 32'd0);
      chk($sformatf("reset u%0d out_valid", u), 32'(ov_s[u]), 32'd0);
      chk($sformatf("reset u%0d busy", u), 32'(busy_s[u]), 32'd0);
      chk($sformatf("reset u%0d out_data", u), 32'(od_s[u]), 32'd0);
      chk($sformatf("reset u%0d out_dist", u), 32'(odist_s[u]), 32'd0);
      chk($sformatf("reset u%0d out_index", u), 32'(oidx_s[u]), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 7; k++) begin
      q_s.delete(); q_v.delete();
      for (int j = 0; j < tbl[k].n; j++) q_s.push_back(tbl[k].s[j]);
      run_frame(tbl[k].u, tbl[k].r, 1'b0, $sformatf("vec%0d", k));
      check_res(tbl[k].u, tbl[k].ed, tbl[k].edist, tbl[k].eidx, $sformatf("vec%0d", k));
      do_ack(tbl[k].u, $sformatf("vec%0d", k));
    end

    // Backpressure and hold
    q_s = '{8'd60, 8'd40, 8'd50, 8'd70};
    q_v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    run_frame(0, 8'd50, 1'b0, "bp");
    check_res(0, 8'd50, 8'd0, 8'd2, "bp");
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d out_valid", c), 32'(ov_s[0]), 32'd1);
      chk($sformatf("hold%0d out_data", c), 32'(od_s[0]), 32'd50);
      chk($sformatf("hold%0d out_dist", c), 32'(odist_s[0]), 32'd0);
      chk($sformatf("hold%0d out_index", c), 32'(oidx_s[0]), 32'd2);
    end
    do_ack(0, "bp");
    q_v.delete();

    // Ignored start during COLLECT and DONE, then start right after ack
    q_s = '{8'd90, 8'd120, 8'd105, 8'd95};
    run_frame(0, 8'd100, 1'b1, "ign");
    start_s[0] = 1'b1; ref_s[0] = 8'd200;
    repeat (3) begin @(posedge clk); #1; end
    start_s[0] = 1'b0; ref_s[0] = 8'd0;
    check_res(0, 8'd105, 8'd5, 8'd2, "ign");
    do_ack(0, "ign");
    q_s = '{8'd10, 8'd20, 8'd30, 8'd40};
    run_frame(0, 8'd50, 1'b0, "after_ack");
    check_res(0, 8'd40, 8'd10, 8'd3, "after_ack");
    do_ack(0, "after_ack");

    // Mid-frame asynchronous reset after 2 of 4 samples
    start_s[0] = 1'b1; ref_s[0] = 8'd100;
    @(posedge clk); #1;
    start_s[0] = 1'b0; inv_s[0] = 1'b1; ind_s[0] = 8'd99;
    @(posedge clk); #1;
    ind_s[0] = 8'd98;
    @(posedge clk); #1;
    inv_s[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst in_ready", 32'(rdy_s[0]), 32'd0);
    chk("midrst out_valid", 32'(ov_s[0]), 32'd0);
    chk("midrst busy", 32'(busy_s[0]), 32'd0);
    chk("midrst out_data", 32'(od_s[0]), 32'd0);
    chk("midrst out_dist", 32'(odist_s[0]), 32'd0);
    chk("midrst out_index", 32'(oidx_s[0]), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    q_s = '{8'd200, 8'd210, 8'd220, 8'd230};
    run_frame(0, 8'd100, 1'b0, "postrst");
    check_res(0, 8'd200, 8'd100, 8'd0, "postrst");
    do_ack(0, "postrst");

    // Max frame: N=256, samples 0..255
    q_s.delete();
    for (int j = 0; j < 256; j++) q_s.push_back(8'(j));
    run_frame(2, 8'd128, 1'b0, "max");
    check_res(2, 8'd128, 8'd0, 8'd128, "max");
    do_ack(2, "max");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
